// File: rtl/wb_arb_pkg.sv
// Shared types for the writeback arbiter: grant select and aux queue entry.
package wb_arb_pkg;

    localparam int unsigned BIT_COUNT = 32;
    // Entry address field is sized for the largest supported register file.
    localparam int unsigned ADR_W_MAX = 16;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_PIPE = 2'd1,
        GRANT_AUX  = 2'd2
    } grant_e;

    typedef struct packed {
        logic                 valid;
        logic [ADR_W_MAX-1:0] adr;
        logic [BIT_COUNT-1:0] data;
    } aux_entry_t;

endpackage

// File: rtl/writeback_arbiter_if.sv
// Pipeline/aux writeback requests in, register-file write port out.
interface writeback_arbiter_if #(
    parameter int unsigned AW        = 5,
    parameter int unsigned BIT_COUNT = 32,
    parameter int unsigned CW        = 2
);
    logic                 pipeWbValid;
    logic [AW-1:0]        pipeWbAdr;
    logic [BIT_COUNT-1:0] pipeWbData;
    logic                 pipeStall;
    logic                 auxValid;
    logic                 auxReady;
    logic [AW-1:0]        auxAdr;
    logic [BIT_COUNT-1:0] auxData;
    logic                 WriteEn;
    logic [AW-1:0]        rd1Adr;
    logic [BIT_COUNT-1:0] Rd1;
    logic [CW-1:0]        auxCount;

    modport slave (
        input  pipeWbValid, pipeWbAdr, pipeWbData, auxValid, auxAdr, auxData,
        output pipeStall, auxReady, WriteEn, rd1Adr, Rd1, auxCount
    );

    modport master (
        output pipeWbValid, pipeWbAdr, pipeWbData, auxValid, auxAdr, auxData,
        input  pipeStall, auxReady, WriteEn, rd1Adr, Rd1, auxCount
    );
endinterface

// File: rtl/wb_fifo.sv
// In-order aux result queue; shift structure keeps the head at entry 0 and
// exposes every entry's address/valid for hazard matching.
module wb_fifo import wb_arb_pkg::*; #(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              i_push,
    input  logic                              i_pop,
    input  aux_entry_t                        i_entry,
    output aux_entry_t                        o_head,
    output logic                              o_full,
    output logic [CW-1:0]                     o_count,
    output logic [DEPTH-1:0][ADR_W_MAX-1:0]   o_adr_vec,
    output logic [DEPTH-1:0]                  o_valid_vec
);
    aux_entry_t    r_q      [DEPTH];
    aux_entry_t    w_q_next [DEPTH];
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_wr_idx;

    always_comb begin
        w_q_next = r_q;
        if (i_pop) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                w_q_next[i] = (i == DEPTH - 1) ? '0 : r_q[(i + 1) % DEPTH];
            end
        end
        // On a simultaneous pop the new entry lands one slot lower.
        w_wr_idx = r_count - CW'(i_pop);
        if (i_push) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (CW'(i) == w_wr_idx) w_q_next[i] = i_entry;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) r_q[i] <= '0;
            r_count <= '0;
        end else begin
            r_q     <= w_q_next;
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            o_adr_vec[i]   = r_q[i].adr;
            o_valid_vec[i] = r_q[i].valid;
        end
    end

    assign o_head  = r_q[0];
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_count = r_count;

endmodule

// File: rtl/writeback_arbiter.sv
// Arbitrates the single register-file write port between the pipeline and
// a queue of long-latency aux results, with starvation and hazard overrides.
module writeback_arbiter import wb_arb_pkg::*; #(
    parameter int unsigned REGISTER_COUNT = 32,
    parameter int unsigned AUX_DEPTH      = 2,
    parameter int unsigned STARVE_LIMIT   = 4
) (
    input logic                clk,
    input logic                reset,
    writeback_arbiter_if.slave bus
);
    localparam int unsigned AW = $clog2(REGISTER_COUNT);
    localparam int unsigned CW = $clog2(AUX_DEPTH + 1);
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    aux_entry_t                          w_entry;
    aux_entry_t                          w_head;
    logic                                w_full;
    logic [CW-1:0]                       w_count;
    logic [AUX_DEPTH-1:0][ADR_W_MAX-1:0] w_adr_vec;
    logic [AUX_DEPTH-1:0]                w_valid_vec;
    logic                                w_aux_ready;
    logic                                w_push;
    logic                                w_pop;
    logic                                w_match;
    grant_e                              w_grant;
    logic [SW-1:0]                       r_starve;
    logic [SW-1:0]                       w_starve_next;

    assign w_aux_ready = !reset && !w_full;
    assign w_push      = bus.auxValid && w_aux_ready && (bus.auxAdr != '0);
    assign w_pop       = (w_grant == GRANT_AUX);
    assign w_entry     = '{valid: 1'b1, adr: ADR_W_MAX'(bus.auxAdr), data: bus.auxData};

    wb_fifo #(.DEPTH(AUX_DEPTH)) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_entry     (w_entry),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_count     (w_count),
        .o_adr_vec   (w_adr_vec),
        .o_valid_vec (w_valid_vec)
    );

    always_comb begin
        w_match = 1'b0;
        for (int unsigned i = 0; i < AUX_DEPTH; i++) begin
            if (w_valid_vec[i] && (w_adr_vec[i] == ADR_W_MAX'(bus.pipeWbAdr))) w_match = 1'b1;
        end
    end

    // Reset suppresses every grant so queued entries are dropped unwritten.
    always_comb begin
        w_grant = GRANT_NONE;
        if (!reset) begin
            if (w_head.valid &&
                (!bus.pipeWbValid || (r_starve == SW'(STARVE_LIMIT)) || w_match)) begin
                w_grant = GRANT_AUX;
            end else if (bus.pipeWbValid) begin
                w_grant = GRANT_PIPE;
            end
        end
    end

    always_comb begin
        bus.WriteEn   = 1'b0;
        bus.pipeStall = 1'b0;
        bus.rd1Adr    = '0;
        bus.Rd1       = '0;
        unique case (w_grant)
            GRANT_AUX: begin
                bus.WriteEn   = 1'b1;
                bus.rd1Adr    = AW'(w_head.adr);
                bus.Rd1       = w_head.data;
                bus.pipeStall = bus.pipeWbValid;
            end
            GRANT_PIPE: begin
                bus.WriteEn = (bus.pipeWbAdr != '0);
                bus.rd1Adr  = bus.pipeWbAdr;
                bus.Rd1     = bus.pipeWbData;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_starve_next = r_starve;
        if ((w_grant == GRANT_AUX) || !w_head.valid) begin
            w_starve_next = '0;
        end else if ((w_grant == GRANT_PIPE) && (r_starve != SW'(STARVE_LIMIT))) begin
            w_starve_next = r_starve + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_starve <= '0;
        else       r_starve <= w_starve_next;
    end

    assign bus.auxReady = w_aux_ready;
    assign bus.auxCount = w_count;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench: a queue-based reference model predicts every cycle's
// write-port outputs; a negedge monitor compares them against the DUT.
module tb_writeback_arbiter;
    import wb_arb_pkg::*;

    localparam int unsigned REGS  = 32;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned LIMIT = 4;
    localparam int unsigned AW    = $clog2(REGS);
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic clk   = 1'b0;
    logic reset = 1'b1;

    writeback_arbiter_if #(.AW(AW), .BIT_COUNT(BIT_COUNT), .CW(CW)) bus ();

    writeback_arbiter #(
        .REGISTER_COUNT (REGS),
        .AUX_DEPTH      (DEPTH),
        .STARVE_LIMIT   (LIMIT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic                 we;
        logic                 stall;
        logic                 rdy;
        logic [CW-1:0]        cnt;
        logic [AW-1:0]        adr;
        logic [BIT_COUNT-1:0] data;
    } obs_t;

    typedef struct {
        logic [AW-1:0]        adr;
        logic [BIT_COUNT-1:0] data;
    } ent_t;

    obs_t exp_q[$];
    ent_t mq[$];
    int   starve = 0;
    int   tests  = 0;
    int   fails  = 0;
    int   cyc    = 0;

    // Drive one cycle of inputs and predict the outputs from the arbitration rules.
    task automatic cycle(input bit rst, input bit pv, input logic [AW-1:0] padr,
                         input logic [BIT_COUNT-1:0] pdata, input bit av,
                         input logic [AW-1:0] aadr, input logic [BIT_COUNT-1:0] adata);
        obs_t e;
        bit   match, take_aux, ready;
        @(posedge clk);
        #1;
        reset           = rst;
        bus.pipeWbValid = pv;
        bus.pipeWbAdr   = padr;
        bus.pipeWbData  = pdata;
        bus.auxValid    = av;
        bus.auxAdr      = aadr;
        bus.auxData     = adata;
        e     = '0;
        e.cnt = CW'(mq.size());
        if (rst) begin
            mq.delete();
            starve = 0;
        end else begin
            ready = (mq.size() < DEPTH);
            e.rdy = ready;
            match = 0;
            foreach (mq[i]) if (mq[i].adr == padr) match = 1;
            take_aux = (mq.size() > 0) && (!pv || starve == LIMIT || match);
            if (take_aux) begin
                e.we    = 1'b1;
                e.adr   = mq[0].adr;
                e.data  = mq[0].data;
                e.stall = pv;
            end else if (pv) begin
                e.we   = (padr != 0);
                e.adr  = padr;
                e.data = pdata;
            end
            if (take_aux || mq.size() == 0) starve = 0;
            else if (pv && starve < LIMIT) starve++;
            if (take_aux) void'(mq.pop_front());
            if (av && ready && aadr != 0) mq.push_back('{adr: aadr, data: adata});
        end
        exp_q.push_back(e);
    endtask

    initial begin
        obs_t e, got;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {bus.WriteEn, bus.pipeStall, bus.auxReady, bus.auxCount, bus.rd1Adr, bus.Rd1};
                tests++;
                if (got !== e) begin
                    fails++;
                    $display("FAIL wb_port cyc=%0d got we=%b stall=%b rdy=%b cnt=%0d adr=%0d data=%h want we=%b stall=%b rdy=%b cnt=%0d adr=%0d data=%h",
                             cyc, got.we, got.stall, got.rdy, got.cnt, got.adr, got.data,
                             e.we, e.stall, e.rdy, e.cnt, e.adr, e.data);
                end
                cyc++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.pipeWbValid = 1'b0;
        bus.pipeWbAdr   = '0;
        bus.pipeWbData  = '0;
        bus.auxValid    = 1'b0;
        bus.auxAdr      = '0;
        bus.auxData     = '0;

        repeat (2) cycle(1, 0, 0, 0, 0, 0, 0);
        // Idle pipe: aux x5 written the cycle after enqueue.
        cycle(0, 0, 0, 0, 1, 5, 32'hAA);
        cycle(0, 0, 0, 0, 0, 0, 0);
        // Starvation: x7 waits out four pipe grants, then forces a stall.
        cycle(0, 1, 1, 32'h101, 1, 7, 32'h77);
        for (int i = 2; i < 9; i++) cycle(0, 1, AW'(i), 32'h100 + i, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        // Ordering hazard on x3.
        cycle(0, 0, 0, 0, 1, 3, 32'h11);
        cycle(0, 1, 3, 32'h22, 0, 0, 0);
        cycle(0, 1, 3, 32'h22, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        // Full queue: third push held until a pop frees a slot.
        cycle(0, 1, 1, 32'h1, 1, 9, 32'h90);
        cycle(0, 1, 2, 32'h2, 1, 10, 32'hA0);
        for (int i = 0; i < 5; i++) cycle(0, 1, AW'(12 + i), 32'h3, 1, 11, 32'hB0);
        repeat (4) cycle(0, 0, 0, 0, 0, 0, 0);
        // x0: pipe write suppressed, aux write swallowed.
        cycle(0, 1, 0, 32'h55, 1, 0, 32'h66);
        cycle(0, 0, 0, 0, 0, 0, 0);
        // Reset with two entries queued.
        cycle(0, 1, 1, 32'h1, 1, 20, 32'hC0);
        cycle(0, 1, 2, 32'h2, 1, 21, 32'hC1);
        cycle(1, 1, 3, 32'h3, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);

        for (int n = 0; n < 2000; n++) begin
            cycle(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 9) < 7), AW'($urandom_range(0, 7)), $urandom,
                  ($urandom_range(0, 9) < 4), AW'($urandom_range(0, 7)), $urandom);
        end
        repeat (4) cycle(0, 0, 0, 0, 0, 0, 0);

        @(negedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 The block SHALL have parameter REGISTER_COUNT, default 32, number of architectural registers; address width AW = $clog2(REGISTER_COUNT).
REQ-002 The block SHALL have parameter AUX_DEPTH, default 2, aux queue entries (>=1).
REQ-003 The block SHALL have parameter STARVE_LIMIT, default 4, pipe-won cycles tolerated before aux is forced (>=1).
REQ-004 The block SHALL have ports as follows; data width BIT_COUNT is the global datapath width.
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- pipeWbValid  in  1  pipeline writeback request.
- pipeWbAdr  in  AW  pipeline destination.
- pipeWbData  in  BIT_COUNT  pipeline result.
- pipeStall  out  1  pipeline must hold its writeback this cycle.
- auxValid  in  1  long-latency unit result offered.
- auxReady  out  1  queue can accept.
- auxAdr  in  AW  aux destination.
- auxData  in  BIT_COUNT  aux result.
- WriteEn  out  1  register-file write enable.
- rd1Adr  out  AW  register-file write address.
- Rd1  out  BIT_COUNT  register-file write data.
- auxCount  out  $clog2(AUX_DEPTH+1)  queue occupancy.

Function
REQ-005 Aux results SHALL enter an in-order FIFO on auxValid && auxReady; aux never bypasses the FIFO (minimum one-cycle enqueue-to-write latency).
REQ-006 auxReady SHALL equal (auxCount < AUX_DEPTH), from registered state only; a pop in the same cycle does not raise auxReady.
REQ-007 Aux transfers with auxAdr == 0 SHALL be accepted and discarded (not enqueued).
REQ-008 Grant each cycle, combinational from current state and inputs:
- GRANT_AUX if FIFO non-empty and (!pipeWbValid or starveCnt == STARVE_LIMIT or any valid FIFO entry address == pipeWbAdr);
- else GRANT_PIPE if pipeWbValid;
- else GRANT_NONE.
REQ-009 GRANT_AUX SHALL drive WriteEn=1, rd1Adr/Rd1 from FIFO head, pop head at clock edge, pipeStall = pipeWbValid.
REQ-010 GRANT_PIPE SHALL drive WriteEn = (pipeWbAdr != 0), rd1Adr/Rd1 from pipe inputs, pipeStall=0.
REQ-011 GRANT_NONE SHALL drive WriteEn=0, pipeStall=0; rd1Adr/Rd1 are don't-care but SHALL be 0.
REQ-012 starveCnt SHALL increment (saturating at STARVE_LIMIT) on GRANT_PIPE with FIFO non-empty, and clear on GRANT_AUX or when the FIFO is empty.
REQ-013 Simultaneous push and pop SHALL leave auxCount unchanged; push to a full FIFO is impossible by REQ-006.
REQ-014 Address match (REQ-008) SHALL check all valid entries, so older aux writes to the same register always land before the stalled pipe write.
REQ-015 The register file samples WriteEn/rd1Adr/Rd1 on the falling clock edge; the outputs SHALL therefore be stable from shortly after the rising edge.

Reset
REQ-016 While reset is high at a rising edge: auxCount=0, FIFO entries invalid, starveCnt=0.
REQ-017 During and after reset, with FIFO empty: WriteEn=0, pipeStall=0, auxReady=0 while reset is asserted, auxReady=1 in the first cycle after reset.
REQ-018 Reset mid-operation SHALL drop all queued aux results without writing them.

Structure
REQ-019 The grant enum (GRANT_NONE, GRANT_PIPE, GRANT_AUX) and the aux entry struct (valid, adr, data) SHALL live in shared package wb_arb_pkg.
REQ-020 The FIFO SHALL be one sub-module, wb_fifo, exposing push, pop, head, full, count and per-entry address/valid vectors for the match.

Verification
REQ-021 Idle pipe: aux write x5=0xAA at cycle 0 -> WriteEn=1, rd1Adr=5, Rd1=0xAA at cycle 1; pipeStall=0.
REQ-022 Starvation: aux x7 queued, pipe valid to distinct addresses every cycle -> pipe granted 4 cycles, then x7 written with pipeStall=1 on cycle 5, starveCnt=0 after.
REQ-023 Ordering: aux x3=0x11 queued, pipe x3=0x22 valid -> x3=0x11 written first with pipeStall=1, then 0x22 next cycle; final x3=0x22.
REQ-024 Full: three back-to-back aux pushes with pipe busy -> auxReady=0 after two, third held until pop; no entry lost.
REQ-025 x0 handling: pipe write x0 -> WriteEn=0; aux write x0 -> accepted, auxCount stays 0.
REQ-026 Reset with auxCount=2 -> auxCount=0 next cycle, no WriteEn for dropped entries.
